mem_stream_writer: RTL and testbench
====================================

Name: mem_stream_writer

Overview:
- Write-side counterpart to the team's synchronous-read ROM/RAM blocks.
- Accepts a command (base address, word count), then consumes a valid/ready data stream and drives a single synchronous memory write port, one word per cycle.
- Sits between a data producer (DMA, UART bridge, loader) and a dual-port RAM whose read port feeds the existing read path.
- Reports completion, word count and framing errors.

Parameters:
- DATA_WIDTH, 8: width of stream data and memory word.
- ADDR_WIDTH, 8: memory address width; depth = 2**ADDR_WIDTH.
- LEN_WIDTH, 9: width of the command length; must be >= ADDR_WIDTH+1 so a full-depth load is expressible.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_addr_i  in  ADDR_WIDTH  base write address.
- cmd_len_i  in  LEN_WIDTH  number of words to write (0 allowed).
- s_valid_i  in  1  stream beat valid.
- s_ready_o  out  1  stream beat accepted when valid&ready.
- s_data_i  in  DATA_WIDTH  beat data.
- s_last_i  in  1  producer's end-of-frame marker.
- mem_we_o  out  1  write enable, registered.
- mem_addr_o  out  ADDR_WIDTH  write address, registered.
- mem_data_o  out  DATA_WIDTH  write data, registered.
- done_o  out  1  one-cycle completion pulse.
- words_o  out  LEN_WIDTH  words written by last command; valid while done_o=1 and held until next command is accepted.
- err_o  out  1  sticky framing error; cleared on next command accept.
- checksum_o  out  DATA_WIDTH  see Optional Feature.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; every output 0, including cmd_ready_o and s_ready_o. Counters and latched command are cleared.
- Reset mid-operation: aborts immediately. No further mem_we_o, no done_o; the partial write is left in memory.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - cmd_ready_o=1, s_ready_o=0.
  - On cmd handshake: latch base and length, clear count/err/checksum.
  - Next state is WRITE if len!=0, otherwise DONE.
- WRITE:
  - cmd_ready_o=0, s_ready_o=1.
  - Each accepted beat k (0-based) produces, one cycle later, mem_we_o=1, mem_addr_o=(base+k) mod 2**ADDR_WIDTH, mem_data_o=beat data.
  - Cycles with no beat give mem_we_o=0; addr/data hold their last value.
- Termination: the frame ends on the beat where k==len-1 OR s_last_i=1, whichever comes first. That beat is still written. Next state is DONE.
- err_o is set when:
  - s_last_i=1 on a beat with k<len-1 (early last), or
  - s_last_i=0 on beat k==len-1 (missing last).
- Surplus beats after termination are not accepted (s_ready_o=0); they stay with the producer.
- DONE: lasts exactly one cycle.
  - done_o=1; words_o = beats written (0 for len=0); err_o is valid.
  - The final word's mem_we_o coincides with this cycle.
  - Then IDLE.
- Latency:
  - cmd accept in cycle N, first beat acceptable in N+1.
  - Final beat in cycle M gives final write and done_o in M+1, and cmd_ready_o=1 in M+2.
- Throughput: one word per cycle sustained under back-to-back valid.
- Address wrap: base+k overflowing 2**ADDR_WIDTH wraps to 0. If len > depth, earlier words are overwritten; this is legal and not flagged.
- cmd_valid_i outside IDLE is ignored (not accepted).

Optional Feature:
- Macro MEM_STREAM_WRITER_CHECKSUM_EN.
- Defined: checksum_o = XOR of all words written by the current command. Cleared on command accept, updated per written word, final value valid with done_o and held until next accept.
- Undefined: checksum_o tied to 0; no checksum logic is synthesised.

Decomposition:
- Package mem_stream_writer_pkg holds:
  - state_t enum {IDLE, WRITE, DONE};
  - localparam-derived function for depth;
  - default width constants.
- No sub-module inside the block; the counter and FSM are small.
- The bench instantiates the block together with the team's synchronous dual-port RAM to read back contents.

Test Plan:
- Reset, then cmd addr=0x10 len=4, beats 0xA1..0xA4 with last on the 4th:
  - writes 0x10..0x13 one cycle after each beat;
  - done_o in the 4th write cycle, words_o=4, err_o=0;
  - checksum_o=0xA1^0xA2^0xA3^0xA4=0x04 when enabled.
- cmd addr=0xFE len=4, data 1..4:
  - writes at 0xFE, 0xFF, 0x00, 0x01;
  - readback through the RAM matches.
- cmd len=0:
  - no mem_we_o;
  - done_o one cycle after accept, words_o=0, err_o=0;
  - s_ready_o stays 0.
- cmd len=5, s_last_i on 3rd beat:
  - 3 writes, done_o, words_o=3, err_o=1;
  - the next command clears err_o.
- cmd len=8, rst_i pulsed after 3 beats:
  - no writes after reset, no done_o;
  - all outputs 0 during reset;
  - cmd_ready_o=1 the cycle after reset deasserts.
- len=16 with s_valid_i toggling randomly:
  - 16 contiguous addresses written in order, no duplicated or dropped beats;
  - done_o exactly once.

Source files
------------

// File: rtl/mem_stream_writer_pkg.sv
// Shared types and defaults for mem_stream_writer.
// Optional checksum output enabled by MEM_STREAM_WRITER_CHECKSUM_EN.
package mem_stream_writer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/mem_stream_writer.sv
// Command-driven stream-to-memory writer: one registered write per accepted beat.
// Build with MEM_STREAM_WRITER_CHECKSUM_EN for a running XOR checksum of written words.
module mem_stream_writer
  import mem_stream_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  words_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_err;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_cmd_hs;
  logic                  w_beat;
  logic                  w_is_last;
  logic                  w_final;

  assign w_cmd_hs  = cmd_valid_i & cmd_ready_o;
  assign w_beat    = s_valid_i & s_ready_o;
  assign w_is_last = (r_cnt == (r_len - LEN_WIDTH'(1)));
  // Frame ends on the length boundary or the producer's last, whichever is first.
  assign w_final   = w_beat & (w_is_last | s_last_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_hs) begin
          w_next = (cmd_len_i != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        if (w_final) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held so nothing is accepted.
  always_comb begin
    cmd_ready_o = 1'b0;
    s_ready_o   = 1'b0;
    done_o      = 1'b0;
    if (!rst_i) begin
      cmd_ready_o = (r_state == IDLE);
      s_ready_o   = (r_state == WRITE);
      done_o      = (r_state == DONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_beat;
      if (w_cmd_hs) begin
        r_base <= cmd_addr_i;
        r_len  <= cmd_len_i;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat) begin
        r_addr <= r_base + r_cnt[ADDR_WIDTH-1:0];
        r_data <= s_data_i;
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
        // Early last and missing last both show up as last disagreeing with the count.
        if (s_last_i != w_is_last) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign mem_we_o   = r_we;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  assign words_o    = r_cnt;
  assign err_o      = r_err;

`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_cksum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cksum <= '0;
    end else if (w_cmd_hs) begin
      r_cksum <= '0;
    end else if (w_beat) begin
      r_cksum <= r_cksum ^ s_data_i;
    end
  end

  assign checksum_o = r_cksum;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_mem_stream_writer.sv
// Scoreboard bench for mem_stream_writer with a behavioural RAM behind the write port.
module tb_mem_stream_writer;
  import mem_stream_writer_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int LW    = 9;
  localparam int DEPTH = depth(AW);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          s_last_i = 1'b0;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          done_o;
  logic [LW-1:0] words_o;
  logic          err_o;
  logic [DW-1:0] checksum_o;

  mem_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .s_last_i(s_last_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .done_o(done_o), .words_o(words_o), .err_o(err_o), .checksum_o(checksum_o)
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk_i) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_data_o;
  end

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  logic [15:0] exp_q[$];
  logic [DW-1:0] tb_data [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every write must match the oldest accepted beat.
  always @(negedge clk_i) begin
    logic [15:0] e;
    if (done_o) done_seen++;
    if (mem_we_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", {24'd0, mem_addr_o}, {24'd0, e[15:8]});
        chk("we_data", {24'd0, mem_data_o}, {24'd0, e[7:0]});
      end
    end
  end

  function automatic logic [DW-1:0] exp_ck(input int n);
    logic [DW-1:0] x = '0;
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    for (int i = 0; i < n; i++) x = x ^ tb_data[i];
`else
    x = DW'(n & 0);
`endif
    return x;
  endfunction

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit ok = 0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) ok = 1;
    end
    chk("cmd_accept", {31'd0, ok}, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    chk("s_rdy_after_cmd", {31'd0, s_ready_o}, {31'd0, (l != 0)});
    chk("err_clr_on_cmd", {31'd0, err_o}, 0);
    chk("words_clr_on_cmd", {23'd0, words_o}, 0);
  endtask

  task automatic send_beats(input logic [AW-1:0] base, input int n, input int last_at, input bit gaps);
    int k = 0;
    int iter = 0;
    bit acc;
    while (k < n && iter < 400) begin
      iter++;
      s_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = tb_data[k];
      s_last_i  = (k == last_at);
      @(negedge clk_i);
      acc = s_valid_i && s_ready_o;
      if (acc) exp_q.push_back({base + AW'(k), tb_data[k]});
      @(posedge clk_i); #1;
      if (acc) k++;
    end
    chk("beats_sent", k, n);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_done(input int exp_words, input bit exp_err, input logic [DW-1:0] ck);
    int polls = 0;
    bit seen = 0;
    while (!seen && polls < 40) begin
      @(negedge clk_i);
      polls++;
      if (done_o) seen = 1;
    end
    chk("done_seen", {31'd0, seen}, 1);
    chk("done_lat", polls, 1);
    chk("words", {23'd0, words_o}, exp_words);
    chk("err", {31'd0, err_o}, {31'd0, exp_err});
    chk("checksum", {24'd0, checksum_o}, {24'd0, ck});
    chk("done_we", {31'd0, mem_we_o}, {31'd0, (exp_words != 0)});
    chk("s_rdy_done", {31'd0, s_ready_o}, 0);
    @(negedge clk_i);
    chk("done_pulse", {31'd0, done_o}, 0);
    chk("cmd_rdy_after", {31'd0, cmd_ready_o}, 1);
    chk("words_hold", {23'd0, words_o}, exp_words);
    chk("err_hold", {31'd0, err_o}, {31'd0, exp_err});
    chk("s_rdy_idle", {31'd0, s_ready_o}, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int dc;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_cmd_rdy", {31'd0, cmd_ready_o}, 0);
    chk("rst_we", {31'd0, mem_we_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("cmd_rdy_post_rst", {31'd0, cmd_ready_o}, 1);
    @(posedge clk_i); #1;

    // Basic 4-word frame
    for (int i = 0; i < 4; i++) tb_data[i] = 8'hA1 + 8'(i);
    send_cmd(8'h10, 9'd4);
    send_beats(8'h10, 4, 3, 0);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    wait_done(4, 0, 8'h04);
`else
    wait_done(4, 0, 8'h00);
`endif

    // Address wrap
    for (int i = 0; i < 4; i++) tb_data[i] = 8'(i + 1);
    send_cmd(8'hFE, 9'd4);
    send_beats(8'hFE, 4, 3, 0);
    wait_done(4, 0, exp_ck(4));
    chk("rb_fe", {24'd0, ram[8'hFE]}, 1);
    chk("rb_ff", {24'd0, ram[8'hFF]}, 2);
    chk("rb_00", {24'd0, ram[8'h00]}, 3);
    chk("rb_01", {24'd0, ram[8'h01]}, 4);

    // Zero-length command
    send_cmd(8'h20, 9'd0);
    wait_done(0, 0, 8'h00);

    // Early last with surplus beats held at the producer
    tb_data[0] = 8'h11; tb_data[1] = 8'h22; tb_data[2] = 8'h33;
    send_cmd(8'h30, 9'd5);
    send_beats(8'h30, 3, 2, 0);
    s_valid_i = 1'b1;
    s_data_i  = 8'h44;
    wait_done(3, 1, exp_ck(3));
    s_valid_i = 1'b0;

    // Missing last; the accept also proves the sticky error cleared
    tb_data[0] = 8'h55; tb_data[1] = 8'h66;
    send_cmd(8'h38, 9'd2);
    send_beats(8'h38, 2, -1, 0);
    wait_done(2, 1, exp_ck(2));

    // Reset mid-frame
    for (int i = 0; i < 8; i++) tb_data[i] = 8'hC0 + 8'(i);
    send_cmd(8'h80, 9'd8);
    send_beats(8'h80, 3, -1, 0);
    dc = done_seen;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk("mid_rst_cmd_rdy", {31'd0, cmd_ready_o}, 0);
      chk("mid_rst_s_rdy", {31'd0, s_ready_o}, 0);
      chk("mid_rst_we", {31'd0, mem_we_o}, 0);
      chk("mid_rst_addr", {24'd0, mem_addr_o}, 0);
      chk("mid_rst_data", {24'd0, mem_data_o}, 0);
      chk("mid_rst_done", {31'd0, done_o}, 0);
      chk("mid_rst_words", {23'd0, words_o}, 0);
      chk("mid_rst_err", {31'd0, err_o}, 0);
      chk("mid_rst_ck", {24'd0, checksum_o}, 0);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("cmd_rdy_after_rst", {31'd0, cmd_ready_o}, 1);
    repeat (2) @(negedge clk_i);
    chk("no_done_on_rst", done_seen, dc);
    @(posedge clk_i); #1;

    // Random valid gaps, 16 words
    for (int i = 0; i < 16; i++) tb_data[i] = 8'(i * 7 + 3);
    dc = done_seen;
    send_cmd(8'h40, 9'd16);
    send_beats(8'h40, 16, 15, 1);
    wait_done(16, 0, exp_ck(16));
    chk("done_once", done_seen - dc, 1);
    for (int i = 0; i < 16; i++) chk("rb_rand", {24'd0, ram[8'h40 + 8'(i)]}, {24'd0, tb_data[i]});

    repeat (3) @(negedge clk_i);
    chk("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
